rdr_sel_gen: RTL and testbench

- Parametrised read-row bank selector for the DMT search-area reference buffer.
- Walks the rows of a search area across 1..NUM_AREAS column sub-areas, in a fixed or snake scan.
- Each cycle it emits the within-area row count, the sub-area index and the reference-row bank select.
- The bank select is computed as a wrapping counter, not as a truncated subtraction: modulo is always correct for any NUM_BANKS, including non-power-of-two, and for any offset.

---
 rtl/rdr_sel_gen.sv | 183 ++++++++++++++++++
 tb/tb_rdr_sel_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdr_sel_gen.sv
// Read-row bank selector: walks rows of 1..NUM_AREAS sub-areas in fixed or snake order.
// One output row per accepted step (1-cycle latency); step low holds all state with rd_valid high.
module rdr_sel_gen #(
    parameter int ROW_W     = 7,
    parameter int SEL_W     = 4,
    parameter int NUM_BANKS = 16,
    parameter int AREA_W    = 2,
    parameter int NUM_AREAS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [SEL_W-1:0]  cfg_offset,
    input  logic [AREA_W:0]   cfg_areas,
    input  logic              cfg_dir,
    input  logic              cfg_snake,
    input  logic              step,
    output logic              busy,
    output logic              rd_valid,
    output logic [ROW_W-1:0]  row_count,
    output logic [AREA_W-1:0] area_idx,
    output logic [SEL_W-1:0]  rd_sel,
    output logic              area_last,
    output logic              done,
    output logic              cfg_err
);
    localparam int SUM_W = ((ROW_W > SEL_W) ? ROW_W : SEL_W) + 1;
    localparam int N_SUB = (NUM_BANKS + (1 << ROW_W)) / NUM_BANKS;
    localparam logic [SUM_W-1:0] NB_SUM  = SUM_W'(NUM_BANKS);
    localparam logic [SEL_W:0]   NB_SEL  = (SEL_W + 1)'(NUM_BANKS);
    localparam logic [AREA_W:0]  NA_AREA = (AREA_W + 1)'(NUM_AREAS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  rows_q, rows_d;
    logic [AREA_W:0]   areas_q, areas_d;
    logic              dir0_q, dir0_d;
    logic              snake_q, snake_d;
    logic              dir_q, dir_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [AREA_W-1:0] area_q, area_d;
    logic [SEL_W:0]    sel_q, sel_d;
    logic [SEL_W:0]    first_sel_q, first_sel_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Reduces a sum below 2*max(rows, banks) into 0..NUM_BANKS-1 without truncation.
    function automatic logic [SEL_W:0] bank_mod(input logic [SUM_W-1:0] v);
        logic [SUM_W-1:0] r;
        r = v;
        for (int i = 0; i < N_SUB; i++) begin
            if (r >= NB_SUM) r = r - NB_SUM;
        end
        return r[SEL_W:0];
    endfunction

    logic [SUM_W-1:0] desc_sum;
    logic [SEL_W:0]   first_desc;
    logic [SEL_W:0]   first_sel_cfg;
    logic [SEL_W:0]   sel_p1;
    logic [SEL_W:0]   sel_inc;
    logic [SEL_W:0]   sel_dec;
    logic             cfg_bad;
    logic             row_last;
    logic             area_final;

    assign desc_sum      = SUM_W'(cfg_offset) + SUM_W'(cfg_rows) - SUM_W'(1);
    assign first_desc    = bank_mod(desc_sum);
    assign first_sel_cfg = cfg_dir ? first_desc : {1'b0, cfg_offset};
    assign sel_p1        = sel_q + 1'b1;
    assign sel_inc       = (sel_p1 == NB_SEL) ? '0 : sel_p1;
    assign sel_dec       = (sel_q == '0) ? (NB_SEL - 1'b1) : (sel_q - 1'b1);
    assign cfg_bad       = (cfg_rows == '0) || (cfg_areas == '0) || (cfg_areas > NA_AREA)
                        || ({1'b0, cfg_offset} >= NB_SEL);
    assign row_last      = dir_q ? (row_q == '0) : (row_q == rows_q - 1'b1);
    assign area_final    = (({1'b0, area_q} + 1'b1) == areas_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            areas_q     <= '0;
            dir0_q      <= 1'b0;
            snake_q     <= 1'b0;
            dir_q       <= 1'b0;
            row_q       <= '0;
            area_q      <= '0;
            sel_q       <= '0;
            first_sel_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            areas_q     <= areas_d;
            dir0_q      <= dir0_d;
            snake_q     <= snake_d;
            dir_q       <= dir_d;
            row_q       <= row_d;
            area_q      <= area_d;
            sel_q       <= sel_d;
            first_sel_q <= first_sel_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        areas_d     = areas_q;
        dir0_d      = dir0_q;
        snake_d     = snake_q;
        dir_d       = dir_q;
        row_d       = row_q;
        area_d      = area_q;
        sel_d       = sel_q;
        first_sel_d = first_sel_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        rows_d      = cfg_rows;
                        areas_d     = cfg_areas;
                        dir0_d      = cfg_dir;
                        snake_d     = cfg_snake;
                        dir_d       = cfg_dir;
                        row_d       = cfg_dir ? (cfg_rows - 1'b1) : '0;
                        area_d      = '0;
                        sel_d       = first_sel_cfg;
                        first_sel_d = first_sel_cfg;
                    end
                end
            end
            RUN: begin
                if (step) begin
                    if (!row_last) begin
                        row_d = dir_q ? (row_q - 1'b1) : (row_q + 1'b1);
                        sel_d = dir_q ? sel_dec : sel_inc;
                    end else if (!area_final) begin
                        area_d = area_q + 1'b1;
                        // Snake keeps the boundary row as the first row of the next area.
                        if (snake_q) begin
                            dir_d = ~dir_q;
                        end else begin
                            row_d = dir0_q ? (rows_q - 1'b1) : '0;
                            sel_d = first_sel_q;
                        end
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        rd_valid  = 1'b0;
        area_last = 1'b0;
        if (state_q == RUN) begin
            busy      = 1'b1;
            rd_valid  = 1'b1;
            area_last = row_last;
        end
    end

    assign row_count = row_q;
    assign area_idx  = area_q;
    assign rd_sel    = sel_q[SEL_W-1:0];
    assign done      = done_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_rdr_sel_gen.sv
// Scoreboard bench for rdr_sel_gen: a 16-bank and a 12-bank instance share stimulus,
// each with its own behavioural model queue and output monitor.
`timescale 1ns/1ps
module tb_rdr_sel_gen;
    localparam int ROW_W     = 7;
    localparam int SEL_W     = 4;
    localparam int AREA_W    = 2;
    localparam int NUM_AREAS = 4;

    typedef struct packed {
        logic              busy;
        logic              vld;
        logic [ROW_W-1:0]  row;
        logic [AREA_W-1:0] area;
        logic [SEL_W-1:0]  sel;
        logic              last;
        logic              done;
        logic              err;
    } out_t;

    typedef struct {
        int running;
        int rows;
        int offset;
        int areas;
        int dir0;
        int snake;
        int dir;
        int row;
        int area;
        int done;
        int err;
    } mst_t;

    logic              clk = 1'b0;
    logic              rst, start, step, cfg_dir, cfg_snake;
    logic [ROW_W-1:0]  cfg_rows;
    logic [SEL_W-1:0]  cfg_offset;
    logic [AREA_W:0]   cfg_areas;

    logic              busy16, vld16, last16, done16, err16;
    logic [ROW_W-1:0]  row16;
    logic [AREA_W-1:0] area16;
    logic [SEL_W-1:0]  sel16;
    logic              busy12, vld12, last12, done12, err12;
    logic [ROW_W-1:0]  row12;
    logic [AREA_W-1:0] area12;
    logic [SEL_W-1:0]  sel12;

    out_t a16, a12;
    assign a16 = {busy16, vld16, row16, area16, sel16, last16, done16, err16};
    assign a12 = {busy12, vld12, row12, area12, sel12, last12, done12, err12};

    always #5 clk = ~clk;

    rdr_sel_gen #(.ROW_W(ROW_W), .SEL_W(SEL_W), .NUM_BANKS(16), .AREA_W(AREA_W), .NUM_AREAS(NUM_AREAS)) u16 (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_offset(cfg_offset),
        .cfg_areas(cfg_areas), .cfg_dir(cfg_dir), .cfg_snake(cfg_snake), .step(step),
        .busy(busy16), .rd_valid(vld16), .row_count(row16), .area_idx(area16), .rd_sel(sel16),
        .area_last(last16), .done(done16), .cfg_err(err16));

    rdr_sel_gen #(.ROW_W(ROW_W), .SEL_W(SEL_W), .NUM_BANKS(12), .AREA_W(AREA_W), .NUM_AREAS(NUM_AREAS)) u12 (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_offset(cfg_offset),
        .cfg_areas(cfg_areas), .cfg_dir(cfg_dir), .cfg_snake(cfg_snake), .step(step),
        .busy(busy12), .rd_valid(vld12), .row_count(row12), .area_idx(area12), .rd_sel(sel12),
        .area_last(last12), .done(done12), .cfg_err(err12));

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    out_t q16[$];
    out_t q12[$];
    mst_t m16 = '{default: 0};
    mst_t m12 = '{default: 0};

    function automatic bit active(input out_t o);
        return o.busy | o.vld | o.done | o.err;
    endfunction

    task automatic cmp(input string nm, input out_t a, input out_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t act(busy=%0d vld=%0d row=%0d area=%0d sel=%0d last=%0d done=%0d err=%0d) exp(busy=%0d vld=%0d row=%0d area=%0d sel=%0d last=%0d done=%0d err=%0d)",
                     nm, $time, a.busy, a.vld, a.row, a.area, a.sel, a.last, a.done, a.err,
                     e.busy, e.vld, e.row, e.area, e.sel, e.last, e.done, e.err);
        end
    endtask

    // Reference model: scan walk as plain row/area integers, bank = (offset + row) mod nb.
    task automatic mstep(input mst_t s, input int nb, output mst_t n, output out_t o);
        bit last;
        n = s;
        n.done = 0;
        n.err  = 0;
        if (rst) begin
            n = '{default: 0};
        end else if (s.running == 0) begin
            if (start) begin
                if (cfg_rows == 0 || cfg_areas == 0 || cfg_areas > NUM_AREAS || int'(cfg_offset) >= nb) begin
                    n.err = 1;
                end else begin
                    n.running = 1;
                    n.rows    = int'(cfg_rows);
                    n.offset  = int'(cfg_offset);
                    n.areas   = int'(cfg_areas);
                    n.dir0    = int'(cfg_dir);
                    n.snake   = int'(cfg_snake);
                    n.dir     = int'(cfg_dir);
                    n.area    = 0;
                    n.row     = cfg_dir ? n.rows - 1 : 0;
                end
            end
        end else if (step) begin
            last = (s.dir != 0) ? (s.row == 0) : (s.row == s.rows - 1);
            if (!last) begin
                n.row = (s.dir != 0) ? s.row - 1 : s.row + 1;
            end else if (s.area < s.areas - 1) begin
                n.area = s.area + 1;
                if (s.snake != 0) n.dir = (s.dir != 0) ? 0 : 1;
                else              n.row = (s.dir0 != 0) ? s.rows - 1 : 0;
            end else begin
                n.running = 0;
                n.done    = 1;
            end
        end
        o.busy = (n.running != 0);
        o.vld  = (n.running != 0);
        o.row  = ROW_W'(n.row);
        o.area = AREA_W'(n.area);
        o.sel  = SEL_W'((n.offset + n.row) % nb);
        o.last = (n.running != 0) && ((n.dir != 0) ? (n.row == 0) : (n.row == n.rows - 1));
        o.done = (n.done != 0);
        o.err  = (n.err != 0);
    endtask

    task automatic drive(input logic s, input logic st, input logic r);
        mst_t n;
        out_t o16, o12;
        start = s;
        step  = st;
        rst   = r;
        mstep(m16, 16, n, o16);
        m16 = n;
        mstep(m12, 12, n, o12);
        m12 = n;
        @(posedge clk);
        if (active(o16)) q16.push_back(o16);
        if (active(o12)) q12.push_back(o12);
        #1;
    endtask

    task automatic set_cfg(input int rows, input int off, input int areas, input bit dir, input bit snake);
        cfg_rows   = ROW_W'(rows);
        cfg_offset = SEL_W'(off);
        cfg_areas  = (AREA_W + 1)'(areas);
        cfg_dir    = dir;
        cfg_snake  = snake;
    endtask

    task automatic scan(input int rows, input int off, input int areas, input bit dir, input bit snake, input int nsteps);
        set_cfg(rows, off, areas, dir, snake);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < nsteps; i++) drive(1'b0, 1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en && active(a16)) begin
            if (q16.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL out16 t=%0t unexpected output %h, none queued", $time, a16);
            end else begin
                cmp("out16", a16, q16.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && active(a12)) begin
            if (q12.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL out12 t=%0t unexpected output %h, none queued", $time, a12);
            end else begin
                cmp("out12", a12, q12.pop_front());
            end
        end
    end

    initial begin
        set_cfg(1, 0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
        cmp("reset16", a16, '0);
        cmp("reset12", a12, '0);
        mon_en = 1'b1;
        drive(1'b0, 1'b1, 1'b0);

        // Wrap past the last bank, step held high.
        scan(12, 6, 1, 1'b0, 1'b0, 12);
        drive(1'b0, 1'b0, 1'b0);
        // Descending with offset near the top of a 12-bank buffer.
        scan(5, 10, 1, 1'b1, 1'b0, 5);
        drive(1'b0, 1'b0, 1'b0);
        // Snake over three areas, then fixed-direction over three descending.
        scan(3, 0, 3, 1'b0, 1'b1, 9);
        drive(1'b0, 1'b0, 1'b0);
        scan(3, 7, 3, 1'b1, 1'b0, 9);
        drive(1'b0, 1'b0, 1'b0);
        scan(1, 11, 4, 1'b1, 1'b1, 4);
        drive(1'b0, 1'b0, 1'b0);

        // Offset 13 is legal for 16 banks only; then illegal areas/rows for both.
        scan(2, 13, 1, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0);
        set_cfg(4, 2, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        set_cfg(4, 2, 5, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        set_cfg(0, 2, 2, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);

        // Start during RUN is ignored.
        scan(4, 3, 2, 1'b0, 1'b0, 1);
        set_cfg(9, 1, 1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // Stall every other cycle, reset at row 5, then a fresh scan.
        scan(10, 3, 1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) drive(1'b0, (i % 2) == 0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        cmp("midrst16", a16, '0);
        cmp("midrst12", a12, '0);
        drive(1'b0, 1'b0, 1'b0);
        scan(6, 9, 2, 1'b1, 1'b1, 12);

        // Back-to-back: start presented during the done cycle.
        set_cfg(4, 5, 1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0)
                set_cfg(int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 15)),
                        int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
        end

        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        n_chk++;
        if (q16.size() != 0) begin
            n_fail++;
            $display("FAIL drain16 %0d entries left, 0 required", q16.size());
        end
        n_chk++;
        if (q12.size() != 0) begin
            n_fail++;
            $display("FAIL drain12 %0d entries left, 0 required", q12.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
